// File: rtl/vga_axil_pkg.sv
// Shared AXI4-Lite types and the address decoder for the VGA control-plane register file.
package vga_axil_pkg;

  localparam int unsigned AXIL_ADDR_W = 32;
  localparam int unsigned AXIL_DATA_W = 32;
  localparam int unsigned MAX_REGS    = 256;
  localparam int unsigned IDX_W       = 8;

  typedef logic [AXIL_ADDR_W-1:0] axil_addr_t;
  typedef logic [AXIL_DATA_W-1:0] axil_data_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } axil_resp_e;

  typedef logic [1:0] axil_resp_t;

  typedef logic [MAX_REGS-1:0] ro_mask_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    axil_resp_e       resp;
  } axil_dec_t;

  // Word index plus response; anything past the last register (including upper bits) is DECERR.
  function automatic axil_dec_t axil_decode(input logic [63:0] addr,
                                            input int unsigned num_regs,
                                            input ro_mask_t ro_mask);
    axil_dec_t   dec;
    logic [63:0] word;
    word     = addr >> 2;
    dec.idx  = '0;
    dec.resp = RESP_DECERR;
    if (word < 64'(num_regs)) begin
      dec.idx  = IDX_W'(word);
      dec.resp = ro_mask[dec.idx] ? RESP_SLVERR : RESP_OKAY;
    end
    return dec;
  endfunction

endpackage

// File: rtl/vga_axil_regfile_if.sv
// AXI4-Lite bus bundle between the VGA control-plane master and the register file.
interface vga_axil_regfile_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  import vga_axil_pkg::*;

  localparam int unsigned STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  axil_resp_t        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  axil_resp_t        rresp;
  logic              rvalid;
  logic              rready;

  modport slave (
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

endinterface

// File: rtl/vga_axil_regfile_wr_ctrl.sv
// AW/W capture and B-channel control; emits a single-cycle commit with the merged address/data.
// Optional assertions under VGA_AXIL_REGFILE_SVA_EN.
module vga_axil_regfile_wr_ctrl
  import vga_axil_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                arst_n,
  vga_axil_regfile_if.slave   axi,
  input  axil_resp_t          wr_resp_i,
  output logic                commit_c,
  output logic [ADDR_W-1:0]   wr_addr_c,
  output logic [DATA_W-1:0]   wr_data_c,
  output logic [DATA_W/8-1:0] wr_strb_c
);

  localparam int unsigned STRB_W = DATA_W / 8;

  logic              aw_held_q, aw_held_d;
  logic              w_held_q,  w_held_d;
  logic              awready_q, awready_d;
  logic              wready_q,  wready_d;
  logic              bvalid_q,  bvalid_d;
  axil_resp_t        bresp_q,   bresp_d;
  logic [ADDR_W-1:0] awaddr_q,  awaddr_d;
  logic [DATA_W-1:0] wdata_q,   wdata_d;
  logic [STRB_W-1:0] wstrb_q,   wstrb_d;

  logic aw_hs, w_hs, b_hs;

  assign aw_hs = axi.awvalid && awready_q;
  assign w_hs  = axi.wvalid  && wready_q;
  assign b_hs  = bvalid_q    && axi.bready;

  // Commit once both halves are available; bvalid blocks a second commit of the same pair.
  assign commit_c  = (aw_held_q || aw_hs) && (w_held_q || w_hs) && !bvalid_q;
  assign wr_addr_c = aw_held_q ? awaddr_q : axi.awaddr;
  assign wr_data_c = w_held_q  ? wdata_q  : axi.wdata;
  assign wr_strb_c = w_held_q  ? wstrb_q  : axi.wstrb;

  always_comb begin
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = axi.awaddr;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = axi.wdata;
      wstrb_d  = axi.wstrb;
    end
    if (commit_c) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_resp_i;
    end
    if (b_hs) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b0;
    end
    awready_d = !aw_held_d && !bvalid_d;
    wready_d  = !w_held_d  && !bvalid_d;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  assign axi.awready = awready_q;
  assign axi.wready  = wready_q;
  assign axi.bvalid  = bvalid_q;
  assign axi.bresp   = bresp_q;

`ifdef VGA_AXIL_REGFILE_SVA_EN
  a_b_src: assert property (@(posedge clk) disable iff (!arst_n)
    bvalid_q |-> (aw_held_q && w_held_q));
`endif

endmodule

// File: rtl/vga_axil_regfile.sv
// AXI4-Lite register file for the VGA control plane: read path, register array and write pulses.
// Optional assertions under VGA_AXIL_REGFILE_SVA_EN.
module vga_axil_regfile
  import vga_axil_pkg::*;
#(
  parameter int unsigned                NUM_REGS = 8,
  parameter int unsigned                ADDR_W   = 32,
  parameter int unsigned                DATA_W   = 32,
  parameter logic [NUM_REGS-1:0]        RO_MASK  = '0,
  parameter logic [NUM_REGS*DATA_W-1:0] RST_VAL  = '0
) (
  input  logic                         clk,
  input  logic                         arst_n,
  vga_axil_regfile_if.slave            axi,
  output logic [NUM_REGS*DATA_W-1:0]   ctrl_o,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_status_i,
  output logic [NUM_REGS-1:0]          wr_pulse_o
);

  localparam int unsigned STRB_W      = DATA_W / 8;
  localparam ro_mask_t    RO_MASK_EXT = MAX_REGS'(RO_MASK);

  typedef logic [NUM_REGS-1:0][DATA_W-1:0] reg_array_t;

  reg_array_t          regs_q,     regs_d;
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
  logic                arready_q,  arready_d;
  logic                rvalid_q,   rvalid_d;
  logic [DATA_W-1:0]   rdata_q,    rdata_d;
  axil_resp_t          rresp_q,    rresp_d;

  logic              commit_c;
  logic [ADDR_W-1:0] wr_addr_c;
  logic [DATA_W-1:0] wr_data_c;
  logic [STRB_W-1:0] wr_strb_c;
  axil_dec_t         dec_wr, dec_rd;
  axil_resp_t        wr_resp;
  logic [DATA_W-1:0] rd_word;
  logic              ar_hs;

  vga_axil_regfile_wr_ctrl #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wr_ctrl (
    .clk       (clk),
    .arst_n    (arst_n),
    .axi       (axi),
    .wr_resp_i (wr_resp),
    .commit_c  (commit_c),
    .wr_addr_c (wr_addr_c),
    .wr_data_c (wr_data_c),
    .wr_strb_c (wr_strb_c)
  );

  assign dec_wr  = axil_decode(64'(wr_addr_c), NUM_REGS, RO_MASK_EXT);
  assign dec_rd  = axil_decode(64'(axi.araddr), NUM_REGS, RO_MASK_EXT);
  assign wr_resp = axil_resp_t'(dec_wr.resp);
  assign ar_hs   = axi.arvalid && arready_q;

  // Byte-masked register update and the matching write pulse.
  always_comb begin
    regs_d     = regs_q;
    wr_pulse_d = '0;
    if (commit_c && dec_wr.resp == RESP_OKAY) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (dec_wr.idx == IDX_W'(i)) begin
          wr_pulse_d[i] = 1'b1;
          for (int unsigned k = 0; k < STRB_W; k++) begin
            if (wr_strb_c[k]) regs_d[i][k*8 +: 8] = wr_data_c[k*8 +: 8];
          end
        end
      end
    end
  end

  // Read data comes from regs_q, so a same-cycle write is not visible to the read.
  always_comb begin
    rd_word = '0;
    if (dec_rd.resp != RESP_DECERR) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (dec_rd.idx == IDX_W'(i)) begin
          rd_word = RO_MASK[i] ? hw_status_i[i*DATA_W +: DATA_W] : regs_q[i];
        end
      end
    end
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_word;
      rresp_d  = (dec_rd.resp == RESP_DECERR) ? RESP_DECERR : RESP_OKAY;
    end else if (rvalid_q && axi.rready) begin
      rvalid_d = 1'b0;
    end
    arready_d = !rvalid_d;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      regs_q     <= RST_VAL;
      wr_pulse_q <= '0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_pulse_q <= wr_pulse_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign ctrl_o      = regs_q;
  assign wr_pulse_o  = wr_pulse_q;
  assign axi.arready = arready_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;

`ifdef VGA_AXIL_REGFILE_SVA_EN
  a_aw_stable: assert property (@(posedge clk) disable iff (!arst_n)
    axi.awvalid && !axi.awready |=> axi.awvalid && $stable(axi.awaddr));
  a_w_stable: assert property (@(posedge clk) disable iff (!arst_n)
    axi.wvalid && !axi.wready |=> axi.wvalid && $stable(axi.wdata) && $stable(axi.wstrb));
  a_ar_stable: assert property (@(posedge clk) disable iff (!arst_n)
    axi.arvalid && !axi.arready |=> axi.arvalid && $stable(axi.araddr));
  a_b_stable: assert property (@(posedge clk) disable iff (!arst_n)
    axi.bvalid && !axi.bready |=> axi.bvalid && $stable(axi.bresp));
  a_r_stable: assert property (@(posedge clk) disable iff (!arst_n)
    axi.rvalid && !axi.rready |=> axi.rvalid && $stable(axi.rdata) && $stable(axi.rresp));
  a_r_src: assert property (@(posedge clk) disable iff (!arst_n)
    $rose(axi.rvalid) |-> $past(axi.arvalid && axi.arready));
  a_pulse_onehot: assert property (@(posedge clk) disable iff (!arst_n)
    $onehot0(wr_pulse_o));
  a_rst_quiet: assert property (@(posedge clk)
    !arst_n |-> (!axi.awready && !axi.wready && !axi.arready && !axi.bvalid && !axi.rvalid &&
                 axi.bresp == '0 && axi.rresp == '0 && axi.rdata == '0 && wr_pulse_o == '0));
`endif

endmodule

// File: tb/tb_vga_axil_regfile.sv
// Directed bench for vga_axil_regfile: 8 registers, register 0 read-only.
module tb_vga_axil_regfile;

  localparam int unsigned NR = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam logic [NR-1:0]    RO  = 8'h01;
  localparam logic [NR*DW-1:0] RST = {32'h0, 32'h0, 32'h0, 32'h0,
                                      32'h5566_7788, 32'h1122_3344, 32'h0000_1234, 32'h0};

  logic              clk    = 1'b0;
  logic              arst_n = 1'b0;
  logic [NR*DW-1:0]  ctrl;
  logic [NR*DW-1:0]  hw_status;
  logic [NR-1:0]     pulse;

  int          n_total    = 0;
  int          n_bad      = 0;
  int          pulse_cnt  = 0;
  logic [NR-1:0] last_pulse = '0;
  logic [31:0] exp_r [NR];

  vga_axil_regfile_if #(.ADDR_W(AW), .DATA_W(DW)) axi();

  vga_axil_regfile #(
    .NUM_REGS (NR),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .RO_MASK  (RO),
    .RST_VAL  (RST)
  ) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .axi         (axi),
    .ctrl_o      (ctrl),
    .hw_status_i (hw_status),
    .wr_pulse_o  (pulse)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    pulse_cnt += $countones(pulse);
    if (|pulse) last_pulse = pulse;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load_rst_model();
    for (int i = 0; i < NR; i++) exp_r[i] = RST[i*32 +: 32];
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NR; i++)
      chk($sformatf("%s_reg%0d", tag, i), 64'(ctrl[i*32 +: 32]), 64'(exp_r[i]));
  endtask

  // W is offered at once, AW aw_dly cycles later; bready stays high.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, output logic [1:0] resp, output int b_cyc);
    bit aw_go, w_go, got_b;
    got_b = 1'b0;
    resp  = 2'b00;
    b_cyc = -1;
    axi.awaddr = a;
    axi.wdata  = d;
    axi.wstrb  = s;
    axi.wvalid = 1'b1;
    axi.bready = 1'b1;
    for (int c = 0; c < 30 && !got_b; c++) begin
      if (c == aw_dly) axi.awvalid = 1'b1;
      aw_go = axi.awvalid && axi.awready;
      w_go  = axi.wvalid && axi.wready;
      if (axi.bvalid) begin
        got_b = 1'b1;
        resp  = axi.bresp;
        b_cyc = c;
      end
      tick();
      if (aw_go) axi.awvalid = 1'b0;
      if (w_go)  axi.wvalid  = 1'b0;
    end
    axi.bready = 1'b0;
    if (!got_b) chk("b_timeout", 0, 1);
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d,
                          output logic [1:0] resp, output int lat);
    bit go;
    lat  = -1;
    d    = '0;
    resp = 2'b00;
    axi.araddr  = a;
    axi.arvalid = 1'b1;
    for (int c = 0; c < 20 && axi.arvalid; c++) begin
      go = axi.arready;
      tick();
      if (go) axi.arvalid = 1'b0;
    end
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      if (axi.rvalid) begin
        lat  = c;
        d    = axi.rdata;
        resp = axi.rresp;
      end else begin
        tick();
      end
    end
    axi.rready = 1'b1;
    tick();
    axi.rready = 1'b0;
    if (lat < 0) chk("r_timeout", 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd;
    int          bc, lat, p0;

    axi.awaddr = '0; axi.awvalid = 1'b0;
    axi.wdata  = '0; axi.wstrb   = '0; axi.wvalid = 1'b0; axi.bready = 1'b0;
    axi.araddr = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
    hw_status = '0;
    hw_status[0*32 +: 32] = 32'hCAFE_0001;
    hw_status[5*32 +: 32] = 32'hFFFF_FFFF;
    load_rst_model();

    // Reset state
    repeat (3) tick();
    chk("rst_awready", 64'(axi.awready), 0);
    chk("rst_wready",  64'(axi.wready),  0);
    chk("rst_arready", 64'(axi.arready), 0);
    chk("rst_bvalid",  64'(axi.bvalid),  0);
    chk("rst_rvalid",  64'(axi.rvalid),  0);
    chk("rst_rdata",   64'(axi.rdata),   0);
    chk("rst_pulse",   64'(pulse),       0);
    check_regs("rst");
    arst_n = 1'b1;
    tick();
    chk("rel_awready", 64'(axi.awready), 1);
    chk("rel_wready",  64'(axi.wready),  1);
    chk("rel_arready", 64'(axi.arready), 1);

    // AW and W together
    p0 = pulse_cnt;
    axi_write(32'h04, 32'hDEAD_BEEF, 4'hF, 0, resp, bc);
    tick();
    chk("t1_bresp", 64'(resp), 0);
    chk("t1_blat",  64'(bc),   1);
    chk("t1_npulse", 64'(pulse_cnt - p0), 1);
    chk("t1_pulse", 64'(last_pulse), 'h02);
    exp_r[1] = 32'hDEAD_BEEF;
    check_regs("t1");
    axi_read(32'h04, rd, resp, lat);
    chk("t1_rdata", 64'(rd),   'hDEADBEEF);
    chk("t1_rresp", 64'(resp), 0);
    chk("t1_rlat",  64'(lat),  1);

    // W three cycles before AW, one byte lane
    p0 = pulse_cnt;
    axi_write(32'h08, 32'h0000_00AA, 4'h1, 3, resp, bc);
    tick();
    chk("t2_bresp", 64'(resp), 0);
    chk("t2_blat",  64'(bc),   4);
    chk("t2_npulse", 64'(pulse_cnt - p0), 1);
    chk("t2_pulse", 64'(last_pulse), 'h04);
    exp_r[2] = 32'h1122_33AA;
    check_regs("t2");

    // Out-of-range addresses
    p0 = pulse_cnt;
    axi_write(32'h20, 32'hDEAD_DEAD, 4'hF, 0, resp, bc);
    chk("t3_bresp_hi", 64'(resp), 3);
    axi_write(32'h8000_0004, 32'hDEAD_DEAD, 4'hF, 0, resp, bc);
    chk("t3_bresp_up", 64'(resp), 3);
    tick();
    chk("t3_npulse", 64'(pulse_cnt - p0), 0);
    check_regs("t3");
    axi_read(32'h20, rd, resp, lat);
    chk("t3_rdata_hi", 64'(rd),   0);
    chk("t3_rresp_hi", 64'(resp), 3);
    axi_read(32'h8000_0004, rd, resp, lat);
    chk("t3_rdata_up", 64'(rd),   0);
    chk("t3_rresp_up", 64'(resp), 3);

    // Read-only register and ignored status slice
    p0 = pulse_cnt;
    axi_write(32'h00, 32'h1234_5678, 4'hF, 0, resp, bc);
    tick();
    chk("t4_bresp", 64'(resp), 2);
    chk("t4_npulse", 64'(pulse_cnt - p0), 0);
    check_regs("t4");
    axi_read(32'h00, rd, resp, lat);
    chk("t4_rdata_ro", 64'(rd),   'hCAFE0001);
    chk("t4_rresp_ro", 64'(resp), 0);
    axi_read(32'h14, rd, resp, lat);
    chk("t4_rdata_rw", 64'(rd),   0);
    chk("t4_rresp_rw", 64'(resp), 0);

    // Unaligned address, partial strobe, then zero strobe
    p0 = pulse_cnt;
    axi_write(32'h0F, 32'hAABB_CCDD, 4'hC, 0, resp, bc);
    tick();
    chk("t4_bresp_strb", 64'(resp), 0);
    chk("t4_pulse_strb", 64'(last_pulse), 'h08);
    exp_r[3] = 32'hAABB_7788;
    axi_write(32'h18, 32'hFFFF_FFFF, 4'h0, 0, resp, bc);
    tick();
    chk("t4_bresp_z", 64'(resp), 0);
    chk("t4_pulse_z", 64'(last_pulse), 'h40);
    chk("t4_npulse_z", 64'(pulse_cnt - p0), 2);
    check_regs("t4b");

    // Same-register write and read in one cycle, then backpressure
    axi.awaddr = 32'h04; axi.wdata = 32'h1234_5678; axi.wstrb = 4'hF;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    axi.araddr = 32'h04; axi.arvalid = 1'b1;
    axi.bready = 1'b0; axi.rready = 1'b0;
    tick();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("t5_bvalid",  64'(axi.bvalid),  1);
      chk("t5_bresp",   64'(axi.bresp),   0);
      chk("t5_rvalid",  64'(axi.rvalid),  1);
      chk("t5_rdata",   64'(axi.rdata),   'hDEADBEEF);
      chk("t5_awready", 64'(axi.awready), 0);
      chk("t5_wready",  64'(axi.wready),  0);
      chk("t5_arready", 64'(axi.arready), 0);
      tick();
    end
    axi.bready = 1'b1; axi.rready = 1'b1;
    tick();
    axi.bready = 1'b0; axi.rready = 1'b0;
    chk("t5_bvalid_off",  64'(axi.bvalid),  0);
    chk("t5_rvalid_off",  64'(axi.rvalid),  0);
    chk("t5_awready_on",  64'(axi.awready), 1);
    chk("t5_arready_on",  64'(axi.arready), 1);
    exp_r[1] = 32'h1234_5678;
    check_regs("t5");

    // Reset with AW held and W still pending
    axi.awaddr = 32'h08; axi.awvalid = 1'b1;
    tick();
    axi.awvalid = 1'b0;
    chk("t6_awready_held", 64'(axi.awready), 0);
    chk("t6_wready_open",  64'(axi.wready),  1);
    arst_n = 1'b0;
    #1;
    chk("t6_wready_rst",  64'(axi.wready),  0);
    chk("t6_arready_rst", 64'(axi.arready), 0);
    chk("t6_bvalid_rst",  64'(axi.bvalid),  0);
    load_rst_model();
    check_regs("t6_rst");
    tick();
    tick();
    arst_n = 1'b1;
    tick();
    axi_write(32'h08, 32'hFEED_FACE, 4'hF, 2, resp, bc);
    chk("t6_bresp", 64'(resp), 0);
    chk("t6_blat",  64'(bc),   3);
    exp_r[2] = 32'hFEED_FACE;
    tick();
    check_regs("t6");
    axi_read(32'h08, rd, resp, lat);
    chk("t6_rdata", 64'(rd), 'hFEEDFACE);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_axil_regfile.md
Name: vga_axil_regfile

Overview:
- Parametrised AXI4-Lite slave register file: the next-generation bus endpoint for the VGA control plane.
- Accepts AW and W independently, in any order or in the same cycle, with byte strobes.
- Returns OKAY, SLVERR or DECERR per access.
- Exposes NUM_REGS registers to the VGA core, with a per-register read-only option for hardware-driven status.

Parameters:
- NUM_REGS, 8, number of 32-bit registers; word-aligned, starting at offset 0.
- ADDR_W, 32, AXI address width; must be >= $clog2(NUM_REGS)+2.
- DATA_W, 32, AXI data width; must be 32 or 64.
- RO_MASK, '0, NUM_REGS-bit mask; bit i=1 means register i is read-only from the bus and reads hw_status_i slice i.
- RST_VAL, '0, NUM_REGS*DATA_W flattened reset values for the writable registers.

Ports:
- clk  in  1  clock
- arst_n  in  1  asynchronous active-low reset
- awaddr  in  ADDR_W ; awvalid in 1 ; awready out 1
- wdata  in  DATA_W ; wstrb in DATA_W/8 ; wvalid in 1 ; wready out 1
- bresp  out  2 ; bvalid out 1 ; bready in 1
- araddr  in  ADDR_W ; arvalid in 1 ; arready out 1
- rdata  out  DATA_W ; rresp out 2 ; rvalid out 1 ; rready in 1
- ctrl_o  out  NUM_REGS*DATA_W  current register contents, flattened, register i at bits [i*DATA_W +: DATA_W]
- hw_status_i  in  NUM_REGS*DATA_W  values returned for RO registers (other slices ignored)
- wr_pulse_o  out  NUM_REGS  one-cycle strobe, the cycle after a successful write to register i

Behaviour:
- Reset (asynchronous, arst_n=0):
  - awready, wready, arready = 0; bvalid, rvalid = 0; bresp, rresp, rdata = 0; wr_pulse_o = 0.
  - Writable registers take RST_VAL.
  - All latched AW/W state is cleared; any in-flight transaction is dropped.
  - Ready signals rise the first cycle after reset release.
- Write path:
  - aw_held and w_held flags capture address and data/strobe.
  - awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
  - Commit happens in the cycle both are held, or both handshake together, or one handshakes while the other is held.
  - bvalid asserts the cycle after commit.
  - bvalid and bresp are held stable until bready; both held flags clear on the B handshake.
  - Back-to-back throughput: one write per 2 cycles when bready is tied high.
- Write decode:
  - idx = addr[$clog2(NUM_REGS)+1:2]; address bits [1:0] are ignored.
  - If (addr>>2) >= NUM_REGS, or any upper bit is set: DECERR, no update.
  - If RO_MASK[idx]: SLVERR, no update.
  - Otherwise OKAY; byte k is updated iff wstrb[k]; wstrb=0 is OKAY with no change but still pulses wr_pulse_o.
- Read path:
  - arready = !rvalid.
  - On AR handshake, rdata and rresp are registered, and rvalid asserts the next cycle (latency 1).
  - Both are held until rready; arready returns high the cycle after the R handshake.
  - Decode matches the write path; DECERR returns rdata=0. RO registers return OKAY with the hw_status_i slice, sampled at the AR handshake.
- Simultaneous events:
  - A read and a committing write to the same register in one cycle: the read returns the pre-write value.
  - Read and write channels are fully independent.
- Data changes: rdata and bresp never change while their valid is high and ready is low.

Optional Feature:
- Macro: VGA_AXIL_REGFILE_SVA_EN.
- When defined, the block compiles in concurrent assertions:
  - VALID stability until handshake, on all five channels.
  - No bvalid without prior AW and W handshakes.
  - No rvalid without a prior AR handshake.
  - wr_pulse_o is onehot0.
  - All outputs are 0 while arst_n=0.
- When undefined: no assertion code; RTL behaviour is identical.

Decomposition:
- vga_axil_pkg holds: axil_addr_t, axil_data_t, axil_resp_e (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3), axil_resp_t, and a decode function returning {idx, resp} from address, NUM_REGS and RO_MASK.
- One natural sub-module, vga_axil_regfile_wr_ctrl, owns the aw_held/w_held capture and B-channel logic. Read logic and the register array stay in the top.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x04 with wstrb=0xF, AW and W in the same cycle -> bresp=OKAY one cycle after commit; wr_pulse_o[1] pulses once; read 0x04 returns 0xDEADBEEF, OKAY, 1 cycle after AR.
- W presented 3 cycles before AW, wdata=0x000000AA, wstrb=0x1, to 0x08 holding 0x11223344 -> register becomes 0x112233AA; bvalid only after the AW handshake.
- Write to 0x20 with NUM_REGS=8 -> DECERR, no ctrl_o change. Read 0x20 -> rdata=0, DECERR.
- RO_MASK=8'h01, hw_status_i slice0=0xCAFE0001: write 0x00 -> SLVERR, no pulse; read 0x00 -> 0xCAFE0001, OKAY.
- bready and rready held low 5 cycles -> bvalid/bresp and rvalid/rdata stable; no new AW, W or AR accepted.
- arst_n asserted mid-write, with AW held and W pending -> outputs 0 immediately; after release, registers equal RST_VAL and the next write completes normally.
